// File: rtl/sram_bytemask_seq_pkg.sv
// Shared definitions for the SRAM byte-mask sequencer: mode codes, FSM
// encoding and the lane helper functions used to build write masks.
package sram_bytemask_pkg;

    // Burst modes, latched on start. Code 3 is handled like FILL.
    localparam logic [1:0] MODE_UNSHUFFLE = 2'd0;
    localparam logic [1:0] MODE_CONV      = 2'd1;
    localparam logic [1:0] MODE_FILL      = 2'd2;

    // Sequencer FSM encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    // Widest mask group_mask() can build; callers size-cast down to LANES.
    localparam int MAX_LANES = 128;

    // Lane permutation for the 16-lane unshuffle pattern.
    function automatic logic [3:0] lane_of(input logic [3:0] p);
        return {p[2], p[0], p[3], p[1]};
    endfunction

    // Active-low mask clearing MSB-first lanes [g*group .. g*group+group-1]
    // of a lanes-wide word. Bits at or above 'lanes' stay 1.
    function automatic logic [MAX_LANES-1:0] group_mask(input int g,
                                                        input int lanes,
                                                        input int group);
        logic [MAX_LANES-1:0] m;
        int lane;
        m = '1;
        for (int i = 0; i < MAX_LANES; i++) begin
            if (i < lanes) begin
                lane = lanes - 1 - i;
                if ((lane >= g * group) && (lane < g * group + group)) begin
                    m[i] = 1'b0;
                end
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/sram_bytemask_seq.sv
// SRAM write-beat sequencer: accepts a burst of beat requests and presents
// one registered pair of active-low byte masks (ports A and B) per beat.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready
// are both high. in_ready depends combinationally on out_ready so the single
// output register sustains one beat per cycle; the output register holds
// its contents unchanged while out_valid && !out_ready.
module sram_bytemask_seq
    import sram_bytemask_pkg::*;
#(
    parameter int LANES = 16,
    parameter int GROUP = 4,
    parameter int CNT_W = 8,
    // Set to 0 to build a non-16-lane variant; UNSHUFFLE beats then write nothing.
    parameter bit ENABLE_UNSHUFFLE = 1'b1,
    localparam int POS_W   = $clog2(LANES),
    localparam int NGROUPS = LANES / GROUP,
    localparam int GIDX_W  = (NGROUPS > 1) ? $clog2(NGROUPS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [CNT_W-1:0]  beats,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [POS_W-1:0]  pos_offset,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LANES-1:0]  mask_a,
    output logic [LANES-1:0]  mask_b,
    output logic [GIDX_W-1:0] group_idx,
    output logic              busy,
    output logic              done,
    output state_t            dbg_state
);

    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO = '0;
    localparam logic [GIDX_W-1:0] GRP_ONE  = GIDX_W'(1);
    localparam logic [GIDX_W-1:0] GRP_LAST = GIDX_W'(NGROUPS - 1);

    // Elaboration-time configuration checks.
    if ((LANES % GROUP) != 0) begin : g_bad_group
        $error("sram_bytemask_seq: LANES must be a multiple of GROUP");
    end
    if (ENABLE_UNSHUFFLE && (LANES != 16)) begin : g_bad_unshuffle
        $error("sram_bytemask_seq: UNSHUFFLE permutation is only defined for LANES=16");
    end

    state_t             state_q, state_d;
    logic [1:0]         mode_q;
    logic [CNT_W-1:0]   beats_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [GIDX_W-1:0]  grp_q;
    logic               out_valid_q;
    logic [LANES-1:0]   mask_a_q, mask_b_q;
    logic [GIDX_W-1:0]  gidx_q;
    logic               done_q;

    logic               in_ready_w;
    logic               accept;
    logic               last_beat;
    logic               fin_exit;
    logic               busy_w;
    logic [LANES-1:0]   unsh_mask;
    logic [LANES-1:0]   mask_a_d, mask_b_d;

    assign accept    = in_valid && in_ready_w;
    assign last_beat = ((cnt_q + CNT_ONE) == beats_q);

    // Single-lane unshuffle mask, only meaningful for the 16-lane layout.
    if (ENABLE_UNSHUFFLE && (LANES == 16)) begin : g_unsh
        localparam logic [LANES-1:0] MSB_ONE = {1'b1, {(LANES-1){1'b0}}};
        assign unsh_mask = ~(MSB_ONE >> lane_of(pos_offset));
    end else begin : g_no_unsh
        assign unsh_mask = '1;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (beats == CNT_ZERO) ? ST_FIN : ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept && last_beat) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                if (!out_valid_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: request acceptance, busy flag, burst-completion condition.
    always_comb begin
        in_ready_w = 1'b0;
        busy_w     = 1'b1;
        fin_exit   = 1'b0;
        case (state_q)
            ST_IDLE: busy_w = 1'b0;
            ST_RUN:  in_ready_w = (cnt_q != beats_q) && (!out_valid_q || out_ready);
            ST_FIN:  fin_exit = !out_valid_q;
            default: busy_w = 1'b0;
        endcase
    end

    // Burst parameters and beat/group counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= MODE_UNSHUFFLE;
            beats_q <= '0;
            cnt_q   <= '0;
            grp_q   <= '0;
        end else if ((state_q == ST_IDLE) && start) begin
            mode_q  <= mode;
            beats_q <= beats;
            cnt_q   <= '0;
            grp_q   <= '0;
        end else if (accept) begin
            cnt_q <= cnt_q + CNT_ONE;
            grp_q <= (grp_q == GRP_LAST) ? '0 : grp_q + GRP_ONE;
        end
    end

    // Mask pattern for the beat being accepted this cycle.
    always_comb begin
        mask_a_d = '1;
        mask_b_d = '1;
        case (mode_q)
            MODE_UNSHUFFLE: mask_a_d = unsh_mask;
            MODE_CONV:      mask_b_d = LANES'(group_mask(int'(grp_q), LANES, GROUP));
            default: begin
                mask_a_d = '0;
                mask_b_d = '0;
            end
        endcase
    end

    // Output register: load on accept, empty on consume, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            mask_a_q    <= '1;
            mask_b_q    <= '1;
            gidx_q      <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            mask_a_q    <= mask_a_d;
            mask_b_q    <= mask_b_d;
            gidx_q      <= grp_q;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
            mask_a_q    <= '1;
            mask_b_q    <= '1;
        end
    end

    // One-cycle completion pulse as FIN hands back to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_q <= 1'b0;
        end else begin
            done_q <= fin_exit;
        end
    end

    assign in_ready  = in_ready_w;
    assign out_valid = out_valid_q;
    assign mask_a    = mask_a_q;
    assign mask_b    = mask_b_q;
    assign group_idx = gidx_q;
    assign busy      = busy_w;
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_sram_bytemask_seq.sv
// Directed bench for sram_bytemask_seq with a scoreboard of expected beats.
module tb_sram_bytemask_seq;
    import sram_bytemask_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [7:0]  beats = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  pos_offset = 4'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] mask_a, mask_b;
    logic [1:0]  group_idx;
    logic        busy, done;
    state_t      dbg_state;

    int total = 0;
    int bad = 0;
    int consumed = 0;
    int done_cnt = 0;

    // {check_gidx, gidx[1:0], mask_a[15:0], mask_b[15:0]}
    logic [34:0] exp_q[$];

    logic [15:0] unsh_tab[16] = '{16'h7FFF, 16'hF7FF, 16'hBFFF, 16'hFBFF,
                                  16'hFF7F, 16'hFFF7, 16'hFFBF, 16'hFFFB,
                                  16'hDFFF, 16'hFDFF, 16'hEFFF, 16'hFEFF,
                                  16'hFFDF, 16'hFFFD, 16'hFFEF, 16'hFFFE};
    logic [15:0] conv_tab[4] = '{16'h0FFF, 16'hF0FF, 16'hFF0F, 16'hFFF0};

    sram_bytemask_seq dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .beats(beats),
        .in_valid(in_valid), .in_ready(in_ready), .pos_offset(pos_offset),
        .out_valid(out_valid), .out_ready(out_ready),
        .mask_a(mask_a), .mask_b(mask_b), .group_idx(group_idx),
        .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #500000;
        bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Scoreboard: compare every consumed beat against the expected queue.
    always @(negedge clk) begin
        logic [34:0] e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("mask_a", {16'd0, mask_a}, {16'd0, e[31:16]});
                check("mask_b", {16'd0, mask_b}, {16'd0, e[15:0]});
                if (e[34]) check("group_idx", {30'd0, group_idx}, {30'd0, e[33:32]});
            end
            consumed++;
        end
        if (done) done_cnt++;
    end

    // Driver: start a burst, then scramble mode/beats to show they are latched.
    task automatic start_burst(input logic [1:0] m, input logic [7:0] b);
        mode = m;
        beats = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        mode = 2'd2;
        beats = 8'hAA;
    endtask

    // Driver: present one beat request and wait for it to be accepted.
    task automatic send_beat(input logic [3:0] p, input logic [34:0] e, output int stalls);
        in_valid = 1'b1;
        pos_offset = p;
        stalls = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(e);
                @(posedge clk); #1;
                return;
            end
            stalls++;
            @(posedge clk); #1;
        end
        check("accept_timeout", 32'd1, 32'd0);
    endtask

    // Wait (bounded) for the done pulse, then confirm it lasts one cycle.
    task automatic wait_done(input string tag);
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int st, st_tot, c0, d0;
        logic [1:0] gi;

        // Power-on reset.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_mask_a", {16'd0, mask_a}, 32'h0000FFFF);
        check("rst_mask_b", {16'd0, mask_b}, 32'h0000FFFF);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_gidx", {30'd0, group_idx}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;

        // UNSHUFFLE, 16 beats, full throughput.
        c0 = consumed; d0 = done_cnt; st_tot = 0;
        start_burst(MODE_UNSHUFFLE, 8'd16);
        for (int i = 0; i < 16; i++) begin
            send_beat(4'(i), {1'b0, 2'b00, unsh_tab[i], 16'hFFFF}, st);
            st_tot += st;
        end
        @(negedge clk);
        check("unsh_in_ready_after_last", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_done("unsh");
        check("unsh_stalls", st_tot, 0);
        check("unsh_count", consumed - c0, 16);
        check("unsh_done_count", done_cnt - d0, 1);

        // CONV, 6 beats: rotating groups.
        c0 = consumed;
        start_burst(MODE_CONV, 8'd6);
        for (int i = 0; i < 6; i++) begin
            gi = 2'(i % 4);
            send_beat(4'd0, {1'b1, gi, 16'hFFFF, conv_tab[gi]}, st);
        end
        in_valid = 1'b0;
        wait_done("conv");
        check("conv_count", consumed - c0, 6);

        // Reset mid-burst with a pending output beat.
        out_ready = 1'b0;
        start_burst(MODE_CONV, 8'd5);
        send_beat(4'd0, {1'b1, 2'd0, 16'hFFFF, conv_tab[0]}, st);
        @(negedge clk);
        check("midrst_pending", {31'd0, out_valid}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_mask_a", {16'd0, mask_a}, 32'h0000FFFF);
        check("midrst_mask_b", {16'd0, mask_b}, 32'h0000FFFF);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;

        // Backpressure on beat 2 of a CONV burst.
        c0 = consumed;
        start_burst(MODE_CONV, 8'd4);
        send_beat(4'd0, {1'b1, 2'd0, 16'hFFFF, conv_tab[0]}, st);
        send_beat(4'd0, {1'b1, 2'd1, 16'hFFFF, conv_tab[1]}, st);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_mask_b", {16'd0, mask_b}, 32'h0000F0FF);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send_beat(4'd0, {1'b1, 2'd2, 16'hFFFF, conv_tab[2]}, st);
        send_beat(4'd0, {1'b1, 2'd3, 16'hFFFF, conv_tab[3]}, st);
        in_valid = 1'b0;
        wait_done("bp");
        check("bp_count", consumed - c0, 4);
        check("bp_queue_empty", exp_q.size(), 0);

        // Zero-length FILL burst: no output, done two cycles after start.
        c0 = consumed;
        start_burst(MODE_FILL, 8'd0);
        @(negedge clk);
        check("zero_done_early", {31'd0, done}, 32'd0);
        check("zero_busy", {31'd0, busy}, 32'd1);
        check("zero_out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("zero_done", {31'd0, done}, 32'd1);
        check("zero_idle", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("zero_done_once", {31'd0, done}, 32'd0);
        check("zero_count", consumed - c0, 0);
        @(posedge clk); #1;

        // FILL, then mode code 3 behaving as FILL.
        c0 = consumed;
        start_burst(MODE_FILL, 8'd3);
        for (int i = 0; i < 3; i++) send_beat(4'(i), {1'b0, 2'd0, 16'h0000, 16'h0000}, st);
        in_valid = 1'b0;
        wait_done("fill");
        start_burst(2'd3, 8'd2);
        for (int i = 0; i < 2; i++) send_beat(4'(i), {1'b0, 2'd0, 16'h0000, 16'h0000}, st);
        in_valid = 1'b0;
        wait_done("mode3");
        check("fill_count", consumed - c0, 5);

        // Second start during RUN is ignored.
        c0 = consumed;
        start_burst(MODE_CONV, 8'd3);
        send_beat(4'd0, {1'b1, 2'd0, 16'hFFFF, conv_tab[0]}, st);
        start = 1'b1; mode = MODE_FILL; beats = 8'd10;
        send_beat(4'd0, {1'b1, 2'd1, 16'hFFFF, conv_tab[1]}, st);
        start = 1'b0;
        send_beat(4'd0, {1'b1, 2'd2, 16'hFFFF, conv_tab[2]}, st);
        @(negedge clk);
        check("restart_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_done("restart");
        check("restart_count", consumed - c0, 3);

        // Maximum beat count completes without counter overflow.
        c0 = consumed; d0 = done_cnt;
        start_burst(MODE_FILL, 8'd255);
        for (int i = 0; i < 255; i++) send_beat(4'd0, {1'b0, 2'd0, 16'h0000, 16'h0000}, st);
        @(negedge clk);
        check("max_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_done("max");
        check("max_count", consumed - c0, 255);
        check("max_done_count", done_cnt - d0, 1);

        check("final_queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
